// File: rtl/dmem_pkg.sv
// Shared types, default sizes and the address-range helper for the Hydra data memory.
package dmem_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DEPTH  = 70;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_e;

    // Addresses are zero-extended to 32 bits, so ADDR_W must not exceed 32.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// Post-reset clear sequencer: walks every word once with a zero write, then
// holds RUN (ready high) until the next reset.
module dmem_clear_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             ready,
    output logic             clear_we,
    output logic [IDX_W-1:0] clear_addr
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    dmem_state_e      state, state_next;
    logic [IDX_W-1:0] count, count_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        count_next = count;
        ready      = 1'b0;
        clear_we   = 1'b0;
        clear_addr = count;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                if (count == LAST) begin
                    state_next = RUN;
                end else begin
                    count_next = count + IDX_W'(1);
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_2r1w.sv
// Dual-read, single-write data memory with hardware clear after reset.
// Define DMEM_BYPASS_EN for write-first forwarding on same-edge read/write hits.
module data_memory_2r1w
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] read_address1,
    input  logic [ADDR_W-1:0] read_address2,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic              rd_valid,
    output logic              ready,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             clear_we;
    logic [IDX_W-1:0] clear_addr;

    dmem_clear_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_clear_ctrl (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    logic              rd1_ok, rd2_ok, wr_ok;
    logic              do_read, do_write, err_next;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] rd1_next, rd2_next;

    always_comb begin
        rd1_ok   = addr_in_range(32'(read_address1), DEPTH);
        rd2_ok   = addr_in_range(32'(read_address2), DEPTH);
        wr_ok    = addr_in_range(32'(write_address), DEPTH);
        do_read  = ready && mem_read;
        do_write = ready && mem_write && wr_ok;
        err_next = ready && ((mem_read && !(rd1_ok && rd2_ok)) || (mem_write && !wr_ok));

        // Clear and user writes never overlap: ready is low for the whole clear.
        arr_we    = clear_we || do_write;
        arr_idx   = clear_we ? clear_addr : write_address[IDX_W-1:0];
        arr_wdata = clear_we ? '0 : write_data;

        rd1_next = rd1_ok ? mem[read_address1[IDX_W-1:0]] : '0;
        rd2_next = rd2_ok ? mem[read_address2[IDX_W-1:0]] : '0;
`ifdef DMEM_BYPASS_EN
        if (do_write && (write_address == read_address1)) begin
            rd1_next = write_data;
        end
        if (do_write && (write_address == read_address2)) begin
            rd2_next = write_data;
        end
`endif
    end

    // NOTE: the array itself is not reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_idx] <= arr_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data1 <= '0;
            out_data2 <= '0;
            rd_valid  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            rd_valid <= do_read;
            addr_err <= err_next;
            if (do_read) begin
                out_data1 <= rd1_next;
                out_data2 <= rd2_next;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_2r1w.sv
// Directed self-checking bench for data_memory_2r1w (DEPTH=70); expected
// forwarding result follows DMEM_BYPASS_EN.
module tb_data_memory_2r1w;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 70;

`ifdef DMEM_BYPASS_EN
    localparam logic [15:0] HIT_EXP = 16'hBEEF;
`else
    localparam logic [15:0] HIT_EXP = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] read_address1, read_address2, write_address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] out_data1, out_data2;
    logic              rd_valid, ready, addr_err;

    int checks = 0;
    int errors = 0;

    data_memory_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .read_address1 (read_address1),
        .read_address2 (read_address2),
        .write_address (write_address),
        .write_data    (write_data),
        .out_data1     (out_data1),
        .out_data2     (out_data2),
        .rd_valid      (rd_valid),
        .ready         (ready),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        read_address1 = '0;
        read_address2 = '0;
        write_address = '0;
        write_data    = '0;
    endtask

    // Counts clear edges; optionally fires a read/write request at edge 10.
    task automatic run_clear(input bit inject);
        for (int e = 1; e <= DEPTH; e++) begin
            if (inject && e == 10) begin
                mem_read      = 1'b1;
                mem_write     = 1'b1;
                read_address1 = 16'd200;
                read_address2 = 16'd3;
                write_address = 16'd3;
                write_data    = 16'hAAAA;
            end
            tick();
            if (inject && e == 10) begin
                check_bit("clear_req_rd_valid", rd_valid, 1'b0);
                check_bit("clear_req_addr_err", addr_err, 1'b0);
                idle();
            end
            check_bit($sformatf("ready_edge%0d", e), ready, (e == DEPTH));
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            mem_read      = 1'b1;
            read_address1 = 16'(i);
            read_address2 = 16'(DEPTH - 1 - i);
            tick();
            check_word($sformatf("%s_p1_%0d", tag, i), out_data1, 16'h0000);
            check_word($sformatf("%s_p2_%0d", tag, DEPTH - 1 - i), out_data2, 16'h0000);
            check_bit($sformatf("%s_valid_%0d", tag, i), rd_valid, 1'b1);
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        check_word("rst_out1", out_data1, 16'h0000);
        check_word("rst_out2", out_data2, 16'h0000);
        check_bit("rst_rd_valid", rd_valid, 1'b0);
        check_bit("rst_ready", ready, 1'b0);
        check_bit("rst_addr_err", addr_err, 1'b0);
        tick();
        reset = 1'b0;

        run_clear(1'b1);
        read_all_zero("clr1");

        // Write then read both ports at the same address.
        mem_write = 1'b1; write_address = 16'd5; write_data = 16'h1234;
        tick();
        check_bit("wr5_rd_valid", rd_valid, 1'b0);
        idle();
        mem_read = 1'b1; read_address1 = 16'd5; read_address2 = 16'd5;
        tick();
        check_word("rd5_p1", out_data1, 16'h1234);
        check_word("rd5_p2", out_data2, 16'h1234);
        check_bit("rd5_valid", rd_valid, 1'b1);
        check_bit("rd5_addr_err", addr_err, 1'b0);
        idle();
        tick();
        check_bit("rd5_valid_pulse", rd_valid, 1'b0);
        check_word("hold_p1", out_data1, 16'h1234);

        // Same-edge write and read of address 9.
        mem_write = 1'b1; write_address = 16'd9; write_data = 16'hBEEF;
        mem_read = 1'b1; read_address1 = 16'd9; read_address2 = 16'd5;
        tick();
        check_word("collide_p1", out_data1, HIT_EXP);
        check_word("collide_p2", out_data2, 16'h1234);
        idle();
        mem_read = 1'b1; read_address1 = 16'd9; read_address2 = 16'd9;
        tick();
        check_word("after_p1", out_data1, 16'hBEEF);
        check_word("after_p2", out_data2, 16'hBEEF);

        // Out-of-range read on port 2 plus out-of-range write.
        idle();
        mem_read = 1'b1; read_address1 = 16'd5; read_address2 = 16'd70;
        mem_write = 1'b1; write_address = 16'd100; write_data = 16'h5555;
        tick();
        check_word("oor_p1", out_data1, 16'h1234);
        check_word("oor_p2", out_data2, 16'h0000);
        check_bit("oor_valid", rd_valid, 1'b1);
        check_bit("oor_err", addr_err, 1'b1);
        idle();
        tick();
        check_bit("oor_err_pulse", addr_err, 1'b0);
        mem_read = 1'b1; read_address1 = 16'd36; read_address2 = 16'd4;
        tick();
        check_word("oor_unchanged36", out_data1, 16'h0000);
        check_word("oor_unchanged4", out_data2, 16'h0000);
        check_bit("inrange_err", addr_err, 1'b0);

        // Every port out of range: still a single pulse.
        idle();
        mem_read = 1'b1; read_address1 = 16'd200; read_address2 = 16'hFFFF;
        mem_write = 1'b1; write_address = 16'd70; write_data = 16'h1111;
        tick();
        check_word("all_oor_p1", out_data1, 16'h0000);
        check_word("all_oor_p2", out_data2, 16'h0000);
        check_bit("all_oor_err", addr_err, 1'b1);
        idle();
        tick();
        check_bit("all_oor_err_pulse", addr_err, 1'b0);

        // Write-only out of range, then last in-range address.
        mem_write = 1'b1; write_address = 16'd70; write_data = 16'h2222;
        tick();
        check_bit("wr_oor_err", addr_err, 1'b1);
        check_bit("wr_oor_valid", rd_valid, 1'b0);
        write_address = 16'd69; write_data = 16'h6969;
        tick();
        check_bit("wr69_err", addr_err, 1'b0);
        idle();
        mem_read = 1'b1; read_address1 = 16'd69; read_address2 = 16'd68;
        tick();
        check_word("rd69", out_data1, 16'h6969);
        check_word("rd68", out_data2, 16'h0000);

        // Populate words, then reset from RUN with live outputs.
        idle();
        mem_write = 1'b1; write_address = 16'd1; write_data = 16'h00FF;
        tick();
        write_address = 16'd0; write_data = 16'h7777;
        tick();
        write_address = 16'd3; write_data = 16'h3333;
        tick();
        idle();
        mem_read = 1'b1; read_address1 = 16'd1; read_address2 = 16'd80;
        tick();
        check_word("pre_rst_p1", out_data1, 16'h00FF);
        check_bit("pre_rst_valid", rd_valid, 1'b1);
        check_bit("pre_rst_err", addr_err, 1'b1);
        idle();
        #2;
        reset = 1'b1;
        #1;
        check_word("run_rst_p1", out_data1, 16'h0000);
        check_bit("run_rst_valid", rd_valid, 1'b0);
        check_bit("run_rst_err", addr_err, 1'b0);
        check_bit("run_rst_ready", ready, 1'b0);
        tick();
        reset = 1'b0;

        // Abort the clear at edge 30, then the full clear must repeat.
        for (int e = 1; e <= 30; e++) begin
            tick();
        end
        check_bit("clear30_ready", ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_bit("clear30_rst_ready", ready, 1'b0);
        check_word("clear30_rst_p1", out_data1, 16'h0000);
        tick();
        reset = 1'b0;
        run_clear(1'b0);
        read_all_zero("clr2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
